// File: rtl/cnt_ctrl_pkg.sv
// rtl/cnt_ctrl_pkg.sv - shared types and mode encodings for the counter sweep sequencer
//
// Purpose : sequencer state type and mode constants, imported by the
//           controller and the bench.
// Ports   : none (package).

package cnt_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_e;

  localparam logic [1:0] MODE_UPWRAP  = 2'b00;
  localparam logic [1:0] MODE_DNWRAP  = 2'b01;
  localparam logic [1:0] MODE_PING    = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

endpackage

// File: rtl/cnt_sweep_ctrl_if.sv
// rtl/cnt_sweep_ctrl_if.sv - control/status bundle between system control and the sweep sequencer
//
// Purpose : groups the sequencer's control inputs and counter/status outputs.
// Signals : start, stop, hold, mode[1:0], limit[WIDTH], cycles[SWEEP_W]  (master -> slave)
//           count[WIDTH], dir, t_en, busy, tc, done                      (slave -> master)
// Modports: master = system control side, slave = sequencer side.

interface cnt_sweep_ctrl_if #(
  parameter int WIDTH   = 3,
  parameter int SWEEP_W = 4
);

  logic               start;
  logic               stop;
  logic               hold;
  logic [1:0]         mode;
  logic [WIDTH-1:0]   limit;
  logic [SWEEP_W-1:0] cycles;

  logic [WIDTH-1:0]   count;
  logic               dir;
  logic               t_en;
  logic               busy;
  logic               tc;
  logic               done;

  modport master (
    output start, stop, hold, mode, limit, cycles,
    input  count, dir, t_en, busy, tc, done
  );

  modport slave (
    input  start, stop, hold, mode, limit, cycles,
    output count, dir, t_en, busy, tc, done
  );

endinterface

// File: rtl/cnt_core.sv
// rtl/cnt_core.sv - WIDTH-bit registered up/down counter with enable and parallel load
//
// Purpose : counter datapath driven by the sweep sequencer.
// Ports   : clk    - clock, rising edge
//           res    - asynchronous active-low reset (q -> 0)
//           en     - count enable
//           dir    - 0 count up, 1 count down
//           ld     - parallel load, takes priority over en
//           ld_val - value loaded when ld is high
//           q      - current count

module cnt_core #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             dir,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = ld_val;
    end else if (en) begin
      q_d = dir ? (q_q - WIDTH'(1)) : (q_q + WIDTH'(1));
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/cnt_sweep_ctrl.sv
// rtl/cnt_sweep_ctrl.sv - sweep sequencer driving a 3-bit up/down counter between 0 and a limit
//
// Purpose : runs up-wrap, down-wrap, ping-pong or one-shot sweeps of the
//           counter for a programmed number of sweeps, with hold/stop/start.
// Ports   : clk - clock, rising edge
//           res - asynchronous active-low reset
//           bus - cnt_sweep_ctrl_if.slave
//                 in : start, stop, hold, mode, limit, cycles
//                 out: count, dir, t_en, busy, tc, done

module cnt_sweep_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int SWEEP_W = 4
) (
  input  logic              clk,
  input  logic              res,
  cnt_sweep_ctrl_if.slave   bus
);

  state_e             state_q;
  logic [1:0]         mode_q;
  logic [WIDTH-1:0]   limit_q;
  logic [SWEEP_W-1:0] cycles_q;
  logic [SWEEP_W-1:0] sweep_q;
  logic               dir_q;
  logic               done_q;

  logic [WIDTH-1:0]   count;
  logic [WIDTH-1:0]   limit_eff;
  logic [WIDTH-1:0]   term_val;
  logic               busy;
  logic               tc;
  logic               last_sweep;
  logic               start_ok;

  logic               core_en;
  logic               core_dir;
  logic               core_ld;
  logic [WIDTH-1:0]   core_ld_val;

  // A zero limit would make an empty sweep; treat it as full scale.
  assign limit_eff = (bus.limit == '0) ? '1 : bus.limit;

  assign start_ok  = (state_q == IDLE) && bus.start && !bus.stop;
  assign busy      = (state_q != IDLE);
  assign term_val  = (state_q == DOWN) ? '0 : limit_q;
  assign tc        = busy && !bus.hold && (count == term_val);

  // cycles == 0 means endless; one-shot always finishes on its first terminal.
  assign last_sweep = (mode_q == MODE_ONESHOT) ||
                      ((cycles_q != '0) &&
                       (({1'b0, sweep_q} + (SWEEP_W+1)'(1)) == {1'b0, cycles_q}));

  // Counter steering: plain counting uses en, every wrap or turnaround is an
  // explicit load so the datapath never relies on modulo roll-over.
  always_comb begin
    core_en     = 1'b0;
    core_ld     = 1'b0;
    core_ld_val = '0;
    core_dir    = (state_q == DOWN);
    if (state_q == IDLE) begin
      if (start_ok) begin
        core_ld     = 1'b1;
        core_ld_val = (bus.mode == MODE_DNWRAP) ? limit_eff : '0;
      end
    end else if (!bus.stop && !bus.hold) begin
      if (tc) begin
        // On the final sweep nothing loads, so count keeps its terminal value.
        if (!last_sweep) begin
          case (mode_q)
            MODE_UPWRAP: begin
              core_ld     = 1'b1;
              core_ld_val = '0;
            end
            MODE_DNWRAP: begin
              core_ld     = 1'b1;
              core_ld_val = limit_q;
            end
            MODE_PING: begin
              core_ld     = 1'b1;
              core_ld_val = (state_q == UP) ? (limit_q - WIDTH'(1)) : WIDTH'(1);
            end
            default: begin
              core_ld     = 1'b0;
            end
          endcase
        end
      end else begin
        core_en = 1'b1;
      end
    end
  end

  cnt_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .res    (res),
    .en     (core_en),
    .dir    (core_dir),
    .ld     (core_ld),
    .ld_val (core_ld_val),
    .q      (count)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q  <= IDLE;
      mode_q   <= '0;
      limit_q  <= '0;
      cycles_q <= '0;
      sweep_q  <= '0;
      dir_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            mode_q   <= bus.mode;
            limit_q  <= limit_eff;
            cycles_q <= bus.cycles;
            sweep_q  <= '0;
            if (bus.mode == MODE_DNWRAP) begin
              state_q <= DOWN;
              dir_q   <= 1'b1;
            end else begin
              state_q <= UP;
              dir_q   <= 1'b0;
            end
          end
        end
        default: begin
          if (bus.stop) begin
            state_q <= IDLE;
          end else if (tc) begin
            // Saturate so an endless run never wraps back to zero sweeps.
            if (sweep_q != '1) begin
              sweep_q <= sweep_q + SWEEP_W'(1);
            end
            if (last_sweep) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else if (mode_q == MODE_PING) begin
              if (state_q == UP) begin
                state_q <= DOWN;
                dir_q   <= 1'b1;
              end else begin
                state_q <= UP;
                dir_q   <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.count = count;
  assign bus.dir   = dir_q;
  assign bus.t_en  = busy && !bus.hold;
  assign bus.busy  = busy;
  assign bus.tc    = tc;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_cnt_sweep_ctrl.sv
// tb/tb_cnt_sweep_ctrl.sv - self-checking bench for cnt_sweep_ctrl
//
// Purpose : drives directed and randomized sweeps and compares every busy
//           cycle against an expected count/dir/tc trace built from sweep rules.
// Ports   : none (top-level bench).

module tb_cnt_sweep_ctrl;

  logic clk;
  logic res;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    logic [2:0] c;
    logic       d;
    logic       t;
  } step_t;

  step_t exp_q[$];

  cnt_sweep_ctrl_if #(.WIDTH(3), .SWEEP_W(4)) bus ();

  cnt_sweep_ctrl #(.WIDTH(3), .SWEEP_W(4)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push(input int v, input logic d, input logic t);
    step_t s;
    s.c = 3'(v);
    s.d = d;
    s.t = t;
    exp_q.push_back(s);
  endfunction

  // Expected busy-cycle trace as a concatenation of whole sweeps.
  function automatic void build_expect(input logic [1:0] m, input int lim, input int segs);
    exp_q.delete();
    for (int s = 0; s < segs; s++) begin
      case (m)
        2'b01: for (int v = lim; v >= 0; v--) push(v, 1'b1, v == 0);
        2'b10: begin
          if (s % 2 == 0) begin
            for (int v = (s == 0) ? 0 : 1; v <= lim; v++) push(v, 1'b0, v == lim);
          end else begin
            for (int v = lim - 1; v >= 0; v--) push(v, 1'b1, v == 0);
          end
        end
        default: for (int v = 0; v <= lim; v++) push(v, 1'b0, v == lim);
      endcase
    end
  endfunction

  task automatic test_reset();
    res = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    tests++; if (bus.busy !== 1'b0)  begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    tests++; if (bus.dir !== 1'b0)   begin fails++; $display("FAIL reset_dir: got %b expected 0", bus.dir); end
    tests++; if (bus.tc !== 1'b0)    begin fails++; $display("FAIL reset_tc: got %b expected 0", bus.tc); end
    tests++; if (bus.done !== 1'b0)  begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    res = 1'b1;
    @(negedge clk);
    #1;
    tests++; if (bus.t_en !== 1'b0)  begin fails++; $display("FAIL idle_t_en: got %b expected 0", bus.t_en); end
  endtask

  task automatic test_sweep(input logic [1:0] m, input int lim, input int cyc,
                            input int hold_pct, input int hold_at, input int stop_after,
                            input string name);
    int L         = (lim == 0) ? 7 : lim;
    int idx       = 0;
    int guard     = 0;
    int held      = 0;
    int hold_left = 0;
    bit hold_done = 1'b0;
    int target;
    build_expect(m, L, (m == 2'b11) ? 1 : ((cyc == 0) ? 8 : cyc));
    target = (stop_after > 0) ? stop_after : exp_q.size();
    @(negedge clk);
    bus.mode   = m;
    bus.limit  = 3'(lim);
    bus.cycles = 4'(cyc);
    bus.start  = 1'b1;
    bus.stop   = 1'b0;
    bus.hold   = 1'b0;
    @(posedge clk);
    while (idx < target && guard < 300) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (hold_left > 0) begin
        bus.hold = 1'b1;
        hold_left--;
      end else if (hold_at >= 0 && !hold_done && exp_q[idx].c == 3'(hold_at)) begin
        hold_done = 1'b1;
        hold_left = 2;
        bus.hold  = 1'b1;
      end else begin
        bus.hold = ($urandom_range(0, 99) < hold_pct);
      end
      #1;
      tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL %s busy step %0d: got %b expected 1", name, idx, bus.busy); end
      tests++; if (bus.count !== exp_q[idx].c) begin fails++; $display("FAIL %s count step %0d: got %0d expected %0d", name, idx, bus.count, exp_q[idx].c); end
      tests++; if (bus.dir !== exp_q[idx].d) begin fails++; $display("FAIL %s dir step %0d: got %b expected %b", name, idx, bus.dir, exp_q[idx].d); end
      tests++; if (bus.tc !== (exp_q[idx].t && !bus.hold)) begin fails++; $display("FAIL %s tc step %0d: got %b expected %b", name, idx, bus.tc, exp_q[idx].t && !bus.hold); end
      tests++; if (bus.t_en !== !bus.hold) begin fails++; $display("FAIL %s t_en step %0d: got %b expected %b", name, idx, bus.t_en, !bus.hold); end
      tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL %s early_done step %0d: got %b expected 0", name, idx, bus.done); end
      if (bus.hold) held++;
      else idx++;
      guard++;
    end
    tests++; if (guard >= 300) begin fails++; $display("FAIL %s timeout: got %0d steps expected %0d", name, idx, target); end
    if (stop_after > 0) begin
      @(negedge clk);
      bus.hold = 1'b0;
      bus.stop = 1'b1;
      #1;
      tests++; if (bus.count !== exp_q[idx].c) begin fails++; $display("FAIL %s stop_cycle_count: got %0d expected %0d", name, bus.count, exp_q[idx].c); end
      @(negedge clk);
      bus.stop = 1'b0;
      #1;
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL %s stop_busy: got %b expected 0", name, bus.busy); end
      tests++; if (bus.count !== exp_q[idx].c) begin fails++; $display("FAIL %s stop_count_hold: got %0d expected %0d", name, bus.count, exp_q[idx].c); end
      tests++; if (bus.dir !== exp_q[idx].d) begin fails++; $display("FAIL %s stop_dir: got %b expected %b", name, bus.dir, exp_q[idx].d); end
      tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL %s stop_done: got %b expected 0", name, bus.done); end
      @(negedge clk);
      #1;
      tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL %s stop_done_late: got %b expected 0", name, bus.done); end
    end else begin
      @(negedge clk);
      bus.hold = 1'b0;
      #1;
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL %s end_busy: got %b expected 0", name, bus.busy); end
      tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL %s end_done: got %b expected 1", name, bus.done); end
      tests++; if (bus.count !== exp_q[$].c) begin fails++; $display("FAIL %s end_count: got %0d expected %0d", name, bus.count, exp_q[$].c); end
      tests++; if (bus.dir !== exp_q[$].d) begin fails++; $display("FAIL %s end_dir: got %b expected %b", name, bus.dir, exp_q[$].d); end
      tests++; if (bus.tc !== 1'b0 || bus.t_en !== 1'b0) begin fails++; $display("FAIL %s end_tc_ten: got %b%b expected 00", name, bus.tc, bus.t_en); end
      tests++; if (idx + held !== exp_q.size() + held || guard !== exp_q.size() + held) begin fails++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, guard, exp_q.size() + held); end
      @(negedge clk);
      #1;
      tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL %s done_width: got %b expected 0", name, bus.done); end
      tests++; if (bus.count !== exp_q[$].c) begin fails++; $display("FAIL %s idle_count: got %0d expected %0d", name, bus.count, exp_q[$].c); end
    end
  endtask

  task automatic test_oneshot_hold();
    test_sweep(2'b11, 4, 5, 0, 2, 0, "oneshot_hold");
    tests++; if (exp_q.size() + 3 !== 8) begin fails++; $display("FAIL oneshot_busy_total: got %0d expected 8", exp_q.size() + 3); end
  endtask

  task automatic test_start_while_busy();
    @(negedge clk);
    bus.mode   = 2'b00;
    bus.limit  = 3'd6;
    bus.cycles = 4'd1;
    bus.start  = 1'b1;
    @(posedge clk);
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      bus.start = (i == 2);
      if (i == 2) begin
        bus.mode   = 2'b01;
        bus.limit  = 3'd2;
        bus.cycles = 4'd3;
      end
      #1;
      tests++; if (bus.count !== 3'(i)) begin fails++; $display("FAIL busy_start count %0d: got %0d expected %0d", i, bus.count, i); end
      tests++; if (bus.tc !== (i == 6)) begin fails++; $display("FAIL busy_start tc %0d: got %b expected %b", i, bus.tc, i == 6); end
    end
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    tests++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin fails++; $display("FAIL busy_start_end: got done=%b busy=%b expected done=1 busy=0", bus.done, bus.busy); end
    tests++; if (bus.count !== 3'd6) begin fails++; $display("FAIL busy_start_final: got %0d expected 6", bus.count); end
  endtask

  task automatic test_start_stop_idle();
    @(negedge clk);
    bus.mode  = 2'b00;
    bus.limit = 3'd3;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL start_stop busy: got %b expected 0", bus.busy); end
    tests++; if (bus.count !== 3'd6) begin fails++; $display("FAIL start_stop count: got %0d expected 6", bus.count); end
    tests++; if (bus.t_en !== 1'b0) begin fails++; $display("FAIL start_stop t_en: got %b expected 0", bus.t_en); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.mode   = 2'b00;
    bus.limit  = 3'd5;
    bus.cycles = 4'd0;
    bus.start  = 1'b1;
    @(posedge clk);
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      tests++; if (bus.count !== 3'(i)) begin fails++; $display("FAIL areset_pre count %0d: got %0d expected %0d", i, bus.count, i); end
    end
    #2;
    res = 1'b0;
    #1;
    tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL areset count: got %0d expected 0", bus.count); end
    tests++; if (bus.busy !== 1'b0)  begin fails++; $display("FAIL areset busy: got %b expected 0", bus.busy); end
    tests++; if (bus.tc !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL areset tc_done: got %b%b expected 00", bus.tc, bus.done); end
    @(negedge clk);
    res = 1'b1;
    test_sweep(2'b00, 2, 1, 0, -1, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int r = 0; r < 14; r++) begin
      logic [1:0] m;
      int lim;
      int cyc;
      m   = 2'($urandom_range(0, 3));
      lim = $urandom_range(0, 7);
      cyc = $urandom_range(1, 3);
      test_sweep(m, lim, cyc, 25, -1, 0, $sformatf("rand%0d_m%0d_l%0d_c%0d", r, m, lim, cyc));
    end
  endtask

  initial begin
    res        = 1'b0;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.hold   = 1'b0;
    bus.mode   = 2'b00;
    bus.limit  = 3'd0;
    bus.cycles = 4'd0;
    test_reset();
    test_sweep(2'b00, 5, 2, 0, -1, 0, "upwrap");
    test_sweep(2'b10, 3, 0, 0, -1, 14, "ping_stop");
    test_sweep(2'b01, 0, 1, 0, -1, 0, "downwrap_lim0");
    test_oneshot_hold();
    test_start_while_busy();
    test_start_stop_idle();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
